// File: rtl/instr_fetch_decode.sv
// -----------------------------------------------------------------------------
// instr_fetch_decode
//   Fetch/decode front end for the 16-bit instruction RAM. Owns the program
//   counter, reads one- and two-word instructions through a combinational RAM
//   port, splits the opcode word into bus-select fields and offers exactly one
//   decoded instruction at a time to the datapath control over valid/ready.
//   JUMPZ/NJUMPZ are resolved here using z_flag at the issue handshake; OVER
//   stops the unit until start or reset.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       run from RESET_PC (honoured in IDLE and HALT)
//   iram_addr    out  ADDR_W  instruction RAM read address (always equals pc)
//   iram_word    in   16      instruction RAM read data, same cycle
//   z_flag       in   1       datapath zero flag for conditional jumps
//   instr_valid  out  1       decoded instruction presented
//   instr_ready  in   1       datapath accepts the presented instruction
//   opcode       out  6       instruction word [15:10]
//   a_sel        out  3       A-bus source, 0 when unused
//   b_sel        out  3       B-bus source, 0 when unused
//   c_sel        out  4       C-bus destination, 0 when none
//   imm          out  16      second word of two-word instructions, else 0
//   pc           out  ADDR_W  program counter (next fetch address)
//   halted       out  1       stopped by OVER or by an illegal condition
//   illegal      out  1       stop was caused by a bad opcode or fetch address
// -----------------------------------------------------------------------------
module instr_fetch_decode #(
    parameter int ADDR_W    = 16,
    parameter int RESET_PC  = 0,
    parameter int ROM_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] iram_addr,
    input  logic [15:0]       iram_word,
    input  logic              z_flag,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [5:0]        opcode,
    output logic [2:0]        a_sel,
    output logic [2:0]        b_sel,
    output logic [3:0]        c_sel,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);
    // One extra bit so a depth equal to 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   L_DEPTH    = (ADDR_W+1)'(ROM_DEPTH);

    localparam logic [5:0] OP_CONST  = 6'd10;
    localparam logic [5:0] OP_JUMPZ  = 6'd14;
    localparam logic [5:0] OP_NJUMPZ = 6'd15;
    localparam logic [5:0] OP_OVER   = 6'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_IMM,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [5:0]        r_opcode;
    logic [2:0]        r_a;
    logic [2:0]        r_b;
    logic [3:0]        r_c;
    logic [15:0]       r_imm;
    logic              r_halted;
    logic              r_illegal;

    logic [5:0] w_op;
    logic       w_alu;
    logic       w_const;
    logic       w_two_word;
    logic       w_legal;
    logic       w_pc_oob;
    logic       w_taken;
    logic       w_issue;

    // Decode of the word currently on the RAM port (used only in FETCH).
    assign w_op       = iram_word[15:10];
    assign w_alu      = (w_op >= 6'd1) && (w_op <= 6'd9);
    assign w_const    = (w_op == OP_CONST);
    assign w_two_word = w_const || (w_op == OP_JUMPZ) || (w_op == OP_NJUMPZ);
    assign w_legal    = (w_op != 6'd0) && (w_op <= OP_OVER);
    assign w_pc_oob   = ({1'b0, r_pc} >= L_DEPTH);

    // Branch decision for the instruction being handed over this cycle.
    assign w_taken = ((r_opcode == OP_JUMPZ)  &&  z_flag) ||
                     ((r_opcode == OP_NJUMPZ) && !z_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= L_RESET_PC;
            r_opcode  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_imm     <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= L_RESET_PC;
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_pc     <= r_pc + ADDR_W'(1);
                    r_opcode <= w_op;
                    r_a      <= w_alu ? iram_word[9:7] : 3'd0;
                    r_b      <= w_alu ? iram_word[6:4] : 3'd0;
                    r_c      <= w_alu   ? iram_word[3:0] :
                                w_const ? iram_word[9:6] : 4'd0;
                    r_imm    <= '0;
                    if (w_pc_oob || !w_legal) begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end else if (w_two_word) begin
                        r_state <= S_FETCH_IMM;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end

                S_FETCH_IMM: begin
                    r_pc  <= r_pc + ADDR_W'(1);
                    r_imm <= iram_word;
                    if (w_pc_oob) begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (instr_ready) begin
                        if (r_opcode == OP_OVER) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            // Out-of-range targets are accepted; the next fetch traps them.
                            if (w_taken) begin
                                r_pc <= ADDR_W'(r_imm);
                            end
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_HALT: begin
                    if (start) begin
                        r_halted  <= 1'b0;
                        r_illegal <= 1'b0;
                        r_pc      <= L_RESET_PC;
                        r_state   <= S_FETCH;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Fields are only driven while an instruction is being offered.
    assign w_issue     = (r_state == S_ISSUE);
    assign instr_valid = w_issue;
    assign opcode      = w_issue ? r_opcode : 6'd0;
    assign a_sel       = w_issue ? r_a      : 3'd0;
    assign b_sel       = w_issue ? r_b      : 3'd0;
    assign c_sel       = w_issue ? r_c      : 4'd0;
    assign imm         = w_issue ? r_imm    : 16'd0;
    assign iram_addr   = r_pc;
    assign pc          = r_pc;
    assign halted      = r_halted;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] iram_addr;
    logic [15:0] iram_word;
    logic        z_flag;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [2:0]  a_sel;
    logic [2:0]  b_sel;
    logic [3:0]  c_sel;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        halted;
    logic        illegal;

    logic [15:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign iram_word = (iram_addr < 16'd1024) ? mem[iram_addr[9:0]] : 16'h0000;

    instr_fetch_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .iram_addr   (iram_addr),
        .iram_word   (iram_word),
        .z_flag      (z_flag),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .c_sel       (c_sel),
        .imm         (imm),
        .pc          (pc),
        .halted      (halted),
        .illegal     (illegal)
    );

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [5:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [3:0]  c;
        logic [15:0] imm;
        int          pc_after;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic        ill;
        logic [5:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [3:0]  c;
        logic [15:0] imm;
        logic [31:0] next;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [15:0] mkw(input int op, input int lo);
        return 16'(op * 1024 + lo);
    endfunction

    // Reference: what the instruction at address p should look like when issued.
    function automatic exp_t predict(input int p);
        exp_t e;
        int   w;
        e = '0;
        if (p >= 512) begin
            e.ill = 1'b1;
            return e;
        end
        w    = int'(mem[p[9:0]]);
        e.op = 6'(w / 1024);
        if (w / 1024 == 0 || w / 1024 > 16) begin
            e.ill = 1'b1;
            return e;
        end
        e.next = 32'(p + 1);
        if (w / 1024 <= 9) begin
            e.a = 3'((w / 128) % 8);
            e.b = 3'((w / 16) % 8);
            e.c = 4'(w % 16);
        end
        if (w / 1024 == 10 || w / 1024 == 14 || w / 1024 == 15) begin
            if (p + 1 >= 512) begin
                e.ill = 1'b1;
                return e;
            end
            e.imm  = mem[(p + 1) % 1024];
            e.next = 32'(p + 2);
            if (w / 1024 == 10) e.c = 4'((w / 64) % 16);
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_word();
        int r;
        int op;
        r = $urandom_range(0, 99);
        if (r < 60)      op = $urandom_range(1, 9);
        else if (r < 70) op = 10;
        else if (r < 78) op = 14;
        else if (r < 86) op = 15;
        else if (r < 95) op = $urandom_range(11, 13);
        else if (r < 97) op = 16;
        else begin
            op = $urandom_range(0, 47);
            if (op != 0) op = op + 16;
        end
        return mkw(op, $urandom_range(0, 1023));
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        start       = 1'b0;
        instr_ready = 1'b0;
        z_flag      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && !halted && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept(input string nm, input logic z, input int exp_pc);
        int n;
        wait_valid(n);
        chk({nm, "_valid"}, instr_valid, 1);
        z_flag      = z;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk({nm, "_pc"}, pc, exp_pc);
    endtask

    task automatic expect_illegal_halt(input string nm);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!halted && n < 8) begin
            if (instr_valid) seen = 1;
            @(negedge clk);
            n++;
        end
        chk({nm, "_halted"}, halted, 1);
        chk({nm, "_illegal"}, illegal, 1);
        chk({nm, "_no_issue"}, seen, 0);
        chk({nm, "_valid"}, instr_valid, 0);
    endtask

    initial begin
        vec_t tbl [8];
        int   n;
        exp_t ex;
        int   m_pc;
        bit   m_halt;
        bit   m_ill;
        int   waitc;

        tbl[0] = '{16'h28C0, 16'd1235, 6'd10, 3'd0, 3'd0, 4'd3, 16'd1235, 2, 2};
        tbl[1] = '{16'h05D2, 16'h0000, 6'd1,  3'd3, 3'd5, 4'd2, 16'd0,    1, 1};
        tbl[2] = '{16'h2798, 16'h0000, 6'd9,  3'd7, 3'd1, 4'd8, 16'd0,    1, 1};
        tbl[3] = '{16'h2FFF, 16'hFFFF, 6'd11, 3'd0, 3'd0, 4'd0, 16'd0,    1, 1};
        tbl[4] = '{16'h3555, 16'h1234, 6'd13, 3'd0, 3'd0, 4'd0, 16'd0,    1, 1};
        tbl[5] = '{16'h3AAA, 16'h0014, 6'd14, 3'd0, 3'd0, 4'd0, 16'd20,   2, 2};
        tbl[6] = '{16'h2A3F, 16'hBEEF, 6'd10, 3'd0, 3'd0, 4'd8, 16'hBEEF, 2, 2};
        tbl[7] = '{16'h40F0, 16'h0000, 6'd16, 3'd0, 3'd0, 4'd0, 16'd0,    1, 1};

        rst_n       = 1'b0;
        start       = 1'b0;
        instr_ready = 1'b0;
        z_flag      = 1'b0;
        clear_mem();
        #1;
        chk("rst_valid",   instr_valid, 0);
        chk("rst_pc",      pc, 0);
        chk("rst_addr",    iram_addr, 0);
        chk("rst_halted",  halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_fields",  {opcode, a_sel, b_sel, c_sel, imm}, 0);

        // Single-instruction decode table.
        foreach (tbl[i]) begin
            apply_reset();
            mem[0] = tbl[i].w0;
            mem[1] = tbl[i].w1;
            pulse_start();
            wait_valid(n);
            chk($sformatf("tbl%0d_lat", i), n, tbl[i].lat);
            chk($sformatf("tbl%0d_op", i), opcode, tbl[i].op);
            chk($sformatf("tbl%0d_a", i), a_sel, tbl[i].a);
            chk($sformatf("tbl%0d_b", i), b_sel, tbl[i].b);
            chk($sformatf("tbl%0d_c", i), c_sel, tbl[i].c);
            chk($sformatf("tbl%0d_imm", i), imm, tbl[i].imm);
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc_after);
        end

        // Constant load, back-pressured ALU op, OVER and restart.
        clear_mem();
        mem[0] = mkw(10, 3 * 64);
        mem[1] = 16'd1235;
        mem[2] = mkw(1, 3 * 128 + 5 * 16 + 2);
        mem[3] = mkw(16, 0);
        apply_reset();
        pulse_start();
        wait_valid(n);
        chk("A_op", opcode, 10);
        chk("A_c", c_sel, 3);
        chk("A_imm", imm, 1235);
        chk("A_pc", pc, 2);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("A_gap", instr_valid, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("A_hold_valid", instr_valid, 1);
            chk("A_hold_op", opcode, 1);
            chk("A_hold_a", a_sel, 3);
            chk("A_hold_b", b_sel, 5);
            chk("A_hold_c", c_sel, 2);
            chk("A_hold_pc", pc, 3);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("A_one_accept", instr_valid, 0);
        @(negedge clk);
        chk("A_over_op", opcode, 16);
        chk("A_over_pc", pc, 4);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("A_halted", halted, 1);
            chk("A_not_illegal", illegal, 0);
            chk("A_halt_valid", instr_valid, 0);
            @(negedge clk);
        end
        pulse_start();
        chk("A_restart_halted", halted, 0);
        wait_valid(n);
        chk("A_restart_op", opcode, 10);
        chk("A_restart_pc", pc, 2);

        // Conditional jumps, ending on an out-of-range target.
        clear_mem();
        mem[0]   = mkw(14, 0);  mem[1]   = 16'd20;
        mem[20]  = mkw(14, 0);  mem[21]  = 16'd100;
        mem[22]  = mkw(15, 0);  mem[23]  = 16'd200;
        mem[200] = mkw(15, 0);  mem[201] = 16'd300;
        mem[202] = mkw(14, 0);  mem[203] = 16'd600;
        apply_reset();
        pulse_start();
        accept("B_jz_taken", 1'b1, 20);
        accept("B_jz_not", 1'b0, 22);
        accept("B_njz_taken", 1'b0, 200);
        accept("B_njz_not", 1'b1, 202);
        accept("B_jz_far", 1'b1, 600);
        expect_illegal_halt("B_oob");

        // Opcode 0 at address 5.
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = mkw(11, 0);
        apply_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) accept("C_merge", 1'b0, i + 1);
        expect_illegal_halt("C_op0");

        // Reset while an instruction is waiting for ready.
        clear_mem();
        mem[0] = mkw(1, 3 * 128 + 5 * 16 + 2);
        apply_reset();
        pulse_start();
        wait_valid(n);
        chk("D_pre_valid", instr_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("D_valid", instr_valid, 0);
        chk("D_pc", pc, 0);
        chk("D_addr", iram_addr, 0);
        chk("D_flags", {halted, illegal}, 0);
        chk("D_fields", {opcode, a_sel, b_sel, c_sel, imm}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("D_no_reissue", instr_valid, 0);
        end
        instr_ready = 1'b0;

        // Random programs against the reference model.
        for (int i = 0; i < 1024; i++) begin
            mem[i] = rand_word();
            if (mem[i][15:10] == 6'd14 || mem[i][15:10] == 6'd15) begin
                if (i < 1023) begin
                    mem[i + 1] = 16'($urandom_range(0, 519));
                    i++;
                end
            end
        end
        apply_reset();
        pulse_start();
        m_pc   = 0;
        m_halt = 0;
        m_ill  = 0;
        waitc  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("R_addr_eq_pc", iram_addr, pc);
            instr_ready = ($urandom_range(0, 2) != 0);
            z_flag      = 1'($urandom_range(0, 1));
            if (m_halt) begin
                chk("R_halted", halted, 1);
                chk("R_illegal", illegal, m_ill);
                chk("R_halt_valid", instr_valid, 0);
                start = ($urandom_range(0, 3) == 0);
                if (start) begin
                    m_halt = 0;
                    m_pc   = 0;
                    waitc  = 0;
                end
            end else begin
                ex = predict(m_pc);
                if (instr_valid) begin
                    waitc = 0;
                    chk("R_legal", ex.ill, 0);
                    chk("R_op", opcode, ex.op);
                    chk("R_a", a_sel, ex.a);
                    chk("R_b", b_sel, ex.b);
                    chk("R_c", c_sel, ex.c);
                    chk("R_imm", imm, ex.imm);
                    chk("R_pc", pc, ex.next);
                    if (instr_ready) begin
                        if (ex.op == 6'd16) begin
                            m_halt = 1;
                            m_ill  = 0;
                        end else if ((ex.op == 6'd14 && z_flag) || (ex.op == 6'd15 && !z_flag)) begin
                            m_pc = int'(ex.imm);
                        end else begin
                            m_pc = int'(ex.next);
                        end
                    end
                end else if (halted) begin
                    chk("R_expect_illegal", ex.ill, 1);
                    m_halt = 1;
                    m_ill  = 1;
                end else begin
                    waitc++;
                    if (waitc > 3) begin
                        chk("R_issue_timeout", waitc, 3);
                        waitc = 0;
                    end
                end
                start = (!m_halt && !halted) ? ($urandom_range(0, 7) == 0) : 1'b0;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
